// File: rtl/booth_pp_accum_if.sv
// booth_pp_accum_if: partial-product input and product output handshakes (err_o present with BOOTH_PP_ACCUM_CHK_EN)
interface booth_pp_accum_if #(parameter int LENGTH = 8);
  localparam int NDIG = LENGTH / 4;
  localparam int CW = $clog2(NDIG) + 1;
  logic [LENGTH+3:0] pp_i;
  logic pp_valid_i;
  logic pp_ready_o;
  logic pp_last_i;
  logic [2*LENGTH-1:0] prod_o;
  logic prod_valid_o;
  logic prod_ready_i;
  logic [CW-1:0] dig_cnt_o;
`ifdef BOOTH_PP_ACCUM_CHK_EN
  logic err_o;
  modport master (output pp_i, pp_valid_i, pp_last_i, prod_ready_i, input pp_ready_o, prod_o, prod_valid_o, dig_cnt_o, err_o);
  modport slave (input pp_i, pp_valid_i, pp_last_i, prod_ready_i, output pp_ready_o, prod_o, prod_valid_o, dig_cnt_o, err_o);
`else
  modport master (output pp_i, pp_valid_i, pp_last_i, prod_ready_i, input pp_ready_o, prod_o, prod_valid_o, dig_cnt_o);
  modport slave (input pp_i, pp_valid_i, pp_last_i, prod_ready_i, output pp_ready_o, prod_o, prod_valid_o, dig_cnt_o);
`endif
endinterface

// File: rtl/booth_pp_accum.sv
// booth_pp_accum: accumulates radix-16 Booth partial products into a signed product (optional checker: BOOTH_PP_ACCUM_CHK_EN)
module booth_pp_accum #(parameter int LENGTH = 8) (
  input logic clk_i,
  input logic rst_i,
  booth_pp_accum_if.slave bus
);
  localparam int NDIG = LENGTH / 4;
  localparam int CW = $clog2(NDIG) + 1;
  localparam int W = 2 * LENGTH;
  typedef enum logic {ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] acc_q, acc_d, prod_q, prod_d, ext, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, last;
  assign ext = {{(W-LENGTH-4){bus.pp_i[LENGTH+3]}}, bus.pp_i};
  assign sum = acc_q + (ext << {cnt_q, 2'b00});
  assign accept = bus.pp_valid_i && state_q == ACC;
  assign last = cnt_q == CW'(NDIG - 1);
  assign bus.pp_ready_o = state_q == ACC;
  assign bus.prod_valid_o = state_q == OUT;
  assign bus.prod_o = prod_q;
  assign bus.dig_cnt_o = cnt_q;
  // weight each digit by 16^k; the last digit publishes the sum and re-arms the accumulator
  always_comb begin
    acc_d = accept ? (last ? '0 : sum) : acc_q;
    cnt_d = accept ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    prod_d = accept && last ? sum : prod_q;
    state_d = state_q == ACC ? (accept && last ? OUT : ACC) : (bus.prod_ready_i ? ACC : OUT);
  end
  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACC;
      acc_q <= '0;
      cnt_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      prod_q <= prod_d;
    end
  end
`ifdef BOOTH_PP_ACCUM_CHK_EN
  localparam logic signed [LENGTH+3:0] LIM = {2'b01, {(LENGTH+2){1'b0}}};
  logic err_q, err_d, oor;
  assign oor = $signed(bus.pp_i) > LIM || $signed(bus.pp_i) < -LIM;
  assign err_d = err_q | (accept && ((bus.pp_last_i != last) || oor));
  assign bus.err_o = err_q;
  // sticky framing / range error, cleared only by reset
  always_ff @(posedge clk_i) err_q <= rst_i ? 1'b0 : err_d;
`else
  logic unused_last;
  assign unused_last = bus.pp_last_i;
`endif
endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Sequential consumer of radix-16 Booth partial products, i.e. the receiving end of the Booth_Ctrl encoder output.
- Accepts one signed partial product per digit, lowest digit first, over a valid/ready handshake.
- Weights digit k by 16^k and accumulates into a 2*LENGTH-bit signed product.
- Presents the product on an output valid/ready handshake, then re-arms for the next multiplication.

Parameters:
- LENGTH, 8: operand width in bits; must be a multiple of 4 and at least 8.
- NDIG, LENGTH/4: number of radix-16 digits per product; derived, not overridden.

Ports:
- clk_i  input  1  clock; all logic rising-edge.
- rst_i  input  1  synchronous reset, active-high.
- pp_i  input  LENGTH+4  signed two's-complement partial product (digit value × multiplicand, range ±8·2^(LENGTH-1)).
- pp_valid_i  input  1  pp_i valid.
- pp_ready_o  output  1  accumulator can accept pp_i.
- pp_last_i  input  1  sideband; marks final digit; used only by the optional feature.
- prod_o  output  2*LENGTH  signed product.
- prod_valid_o  output  1  prod_o valid.
- prod_ready_i  input  1  downstream accepts prod_o.
- dig_cnt_o  output  clog2(NDIG)+1  digits accepted in the current product (debug).

Behaviour:
- States: ACC (accept digits) and OUT (hold result).
- Reset (rst_i=1 at a clock edge): state=ACC; acc=0; dig_cnt=0; prod_o=0; prod_valid_o=0; pp_ready_o=1. Reset overrides everything, including a mid-product reset, which discards partial sums.
- pp_ready_o=1 exactly when state=ACC.
- A digit is accepted on a clock edge where pp_valid_i and pp_ready_o are both 1. On acceptance:
  - acc <= acc + (sign-extend(pp_i) << 4·dig_cnt), computed modulo 2^(2*LENGTH); wrap is silent.
  - dig_cnt <= dig_cnt+1.
- On acceptance of digit NDIG-1:
  - prod_o <= final sum; prod_valid_o <= 1; state <= OUT.
  - acc and dig_cnt clear to 0.
  - Latency: product visible the cycle after the last digit handshake.
- OUT: pp_ready_o=0; prod_o and prod_valid_o held stable until prod_ready_i=1.
- On an edge with prod_valid_o=1 and prod_ready_i=1: prod_valid_o <= 0; state <= ACC. pp_ready_o rises next cycle, so there is no same-cycle digit/product overlap.
- prod_o keeps its last value after handshake; it is only meaningful while prod_valid_o=1.
- pp_valid_i=0 inserts bubbles; dig_cnt and acc hold.
- Back-to-back: a full product takes NDIG accept cycles + 1 OUT cycle minimum (NDIG+1 cycles throughput).
- pp_i is not required to stay stable while pp_ready_o=0.
- dig_cnt_o = dig_cnt; reset value 0.

Optional Feature:
- Macro BOOTH_PP_ACCUM_CHK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o goes sticky-high the cycle after any accepted digit where pp_last_i disagrees with (dig_cnt==NDIG-1).
  - err_o also sets on an accepted pp_i outside ±(8·2^(LENGTH-1)).
  - err_o clears only on rst_i.
  - Accumulation behaviour is unchanged.
- Undefined: err_o port absent; pp_last_i ignored.

Test Plan:
- Reset: assert rst_i 2 cycles mid-product (after 1 digit) -> prod_valid_o=0, pp_ready_o=1, dig_cnt_o=0, prod_o=0. A new product then computes correctly from digit 0.
- LENGTH=8, a=3, b=5: pp_i=15 then 0 -> prod_o=0x000F, prod_valid_o high one cycle after 2nd accept.
- LENGTH=8, a=-7, b=127: pp_i=7 (0x007) then -56 (0xFC8) -> prod_o=0xFC87 (-889).
- Backpressure: hold prod_ready_i=0 5 cycles with pp_valid_i=1 -> pp_ready_o=0, prod_o stable. Release -> next digit accepted the cycle after the product handshake.
- Bubbles: pp_valid_i toggling 1,0,0,1 with pp_i=-8·(-128)=1024 then -1024 -> prod_o=1024-16384=-15360 (0xC400).
- With BOOTH_PP_ACCUM_CHK_EN: pp_last_i=1 on digit 0 -> err_o=1 the next cycle, remains 1 through the product; the product is still 0x000F for the 15,0 stimulus.
